regwr_arbiter: RTL

// Round-robin arbiter sharing the single write port of the CPU register bank
// (array of N-bit CLK-edge registers with load strobes) among NREQ requesters
// (ALU writeback, load unit, PC/ctrl, debug). Grants one write per cycle,

---
 rtl/regwr_arbiter_if.sv | 31 +++
 rtl/regwr_arbiter.sv | 177 +++++++++++++++++
 2 files changed

// File: rtl/regwr_arbiter_if.sv
// Register-bank write-port bus: requester handshake side plus the registered
// write outputs that feed the bank.
interface regwr_arbiter_if #(
  parameter int unsigned N    = 4,
  parameter int unsigned NREQ = 4,
  parameter int unsigned NREG = 8,
  parameter int unsigned AW   = 3
);
  logic [NREQ-1:0]    req;
  logic [NREQ-1:0]    lock;
  logic [NREQ*AW-1:0] addr;
  logic [NREQ*N-1:0]  data;
  logic [NREQ-1:0]    ack;
  logic               we;
  logic [AW-1:0]      waddr;
  logic [N-1:0]       wdata;
  logic [NREG-1:0]    load;
  logic               err;

  // Requesters and bank observer.
  modport master (
    output req, lock, addr, data,
    input  ack, we, waddr, wdata, load, err
  );

  // Arbiter.
  modport slave (
    input  req, lock, addr, data,
    output ack, we, waddr, wdata, load, err
  );
endinterface

// File: rtl/regwr_arbiter.sv
// Round-robin arbiter for the single register-bank write port. One accepted
// write per cycle, optional locked bursts, registered write outputs and
// one-hot load strobes.
module regwr_arbiter #(
  parameter int unsigned N        = 4,
  parameter int unsigned NREQ     = 4,
  parameter int unsigned NREG     = 8,
  parameter int unsigned AW       = 3,
  parameter int unsigned MAXBURST = 4
) (
  input  logic           i_clk,
  input  logic           i_clr,
  regwr_arbiter_if.slave bus
);

  localparam int unsigned PW = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int unsigned CW = $clog2(MAXBURST + 1);
  localparam logic [AW:0] NregLim = (AW + 1)'(NREG);

  typedef enum logic [0:0] {StIdle, StBurst} state_e;

  state_e          r_state, w_state_d;
  logic [PW-1:0]   r_ptr, w_ptr_d;
  logic [PW-1:0]   r_owner, w_owner_d;
  logic [CW-1:0]   r_cnt, w_cnt_d;

  logic            w_gnt_vld;
  logic [PW-1:0]   w_gnt_idx;
  logic [AW-1:0]   w_sel_addr;
  logic [N-1:0]    w_sel_data;
  logic            w_sel_lock;
  logic            w_bad_addr;
  logic [NREG-1:0] w_load_d;

  logic            r_we;
  logic [AW-1:0]   r_waddr;
  logic [N-1:0]    r_wdata;
  logic [NREG-1:0] r_load;
  logic            r_err;

  function automatic logic [PW-1:0] f_next(input logic [PW-1:0] idx);
    f_next = (idx == PW'(NREQ - 1)) ? '0 : idx + 1'b1;
  endfunction

  // Pick the granted requester: burst owner only, else first from ptr upward.
  always_comb begin
    int            idx;
    logic [PW-1:0] idx_p;
    idx       = 0;
    idx_p     = '0;
    w_gnt_vld = 1'b0;
    w_gnt_idx = '0;
    if (r_state == StBurst) begin
      w_gnt_vld = bus.req[r_owner];
      w_gnt_idx = r_owner;
    end else begin
      // Walk backwards so the closest requester to ptr is written last.
      for (int k = int'(NREQ) - 1; k >= 0; k--) begin
        idx = int'(r_ptr) + k;
        if (idx >= int'(NREQ)) idx = idx - int'(NREQ);
        idx_p = PW'(idx);
        if (bus.req[idx_p]) begin
          w_gnt_vld = 1'b1;
          w_gnt_idx = idx_p;
        end
      end
    end
  end

  // Mux the granted requester's address, data and lock.
  always_comb begin
    w_sel_addr = '0;
    w_sel_data = '0;
    w_sel_lock = 1'b0;
    for (int i = 0; i < int'(NREQ); i++) begin
      if (PW'(i) == w_gnt_idx) begin
        w_sel_addr = bus.addr[i*AW +: AW];
        w_sel_data = bus.data[i*N +: N];
        w_sel_lock = bus.lock[i];
      end
    end
    w_bad_addr = {1'b0, w_sel_addr} >= NregLim;
    // Out-of-range addresses match no bit, so the strobe stays clear.
    for (int r = 0; r < int'(NREG); r++) begin
      w_load_d[r] = (w_sel_addr == AW'(r));
    end
  end

  // Combinational one-hot acknowledge, suppressed while in reset.
  always_comb begin
    bus.ack = '0;
    if (!i_clr && w_gnt_vld) bus.ack[w_gnt_idx] = 1'b1;
  end

  // Next-state: burst entry/exit and pointer advance.
  always_comb begin
    w_state_d = r_state;
    w_ptr_d   = r_ptr;
    w_owner_d = r_owner;
    w_cnt_d   = r_cnt;
    case (r_state)
      StIdle: begin
        if (w_gnt_vld) begin
          if (w_sel_lock && (MAXBURST > 1)) begin
            // Pointer stays put until the burst ends.
            w_state_d = StBurst;
            w_owner_d = w_gnt_idx;
            w_cnt_d   = CW'(1);
          end else begin
            w_ptr_d = f_next(w_gnt_idx);
          end
        end
      end
      StBurst: begin
        if (!w_gnt_vld) begin
          w_state_d = StIdle;
          w_ptr_d   = f_next(r_owner);
          w_cnt_d   = '0;
        end else begin
          w_cnt_d = r_cnt + CW'(1);
          if (!w_sel_lock || (int'(r_cnt) + 1 >= int'(MAXBURST))) begin
            w_state_d = StIdle;
            w_ptr_d   = f_next(r_owner);
            w_cnt_d   = '0;
          end
        end
      end
      default: begin
        w_state_d = StIdle;
        w_cnt_d   = '0;
      end
    endcase
  end

  // Arbitration state registers.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_state <= StIdle;
      r_ptr   <= '0;
      r_owner <= '0;
      r_cnt   <= '0;
    end else begin
      r_state <= w_state_d;
      r_ptr   <= w_ptr_d;
      r_owner <= w_owner_d;
      r_cnt   <= w_cnt_d;
    end
  end

  // Registered write port; address/data hold when nothing is accepted.
  always_ff @(posedge i_clk) begin
    if (i_clr) begin
      r_we    <= 1'b0;
      r_waddr <= '0;
      r_wdata <= '0;
      r_load  <= '0;
      r_err   <= 1'b0;
    end else if (w_gnt_vld) begin
      r_we    <= 1'b1;
      r_waddr <= w_sel_addr;
      r_wdata <= w_sel_data;
      r_load  <= w_load_d;
      r_err   <= w_bad_addr;
    end else begin
      r_we    <= 1'b0;
      r_load  <= '0;
      r_err   <= 1'b0;
    end
  end

  assign bus.we    = r_we;
  assign bus.waddr = r_waddr;
  assign bus.wdata = r_wdata;
  assign bus.load  = r_load;
  assign bus.err   = r_err;

endmodule
